ts_ram_pingpong_wr: RTL and testbench

- Upstream write stage for the PCIe TS read path.
- Takes the 8-bit TS byte stream on clk_ts and packs each 188-byte packet into 24 x 64-bit words (padded to 192 bytes).
- Writes those words into a two-bank ping-pong TS RAM.
- Flags each bank full to the clk-domain reader and reopens the bank when the reader returns a release toggle.

---
 rtl/ts_ram_pingpong_wr.sv | 133 +++++++++++++
 tb/tb_ts_ram_pingpong_wr.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_ram_pingpong_wr.sv
// TS byte stream packer: 188-byte packets become 24 x 64-bit words written into a two-bank
// ping-pong RAM, with bank-full handshake to the reader via release toggles.
module ts_ram_pingpong_wr #(
  parameter int unsigned PKTS_PER_BANK = 256,
  parameter logic [7:0]  PAD_BYTE      = 8'hFF
) (
  input  logic        clk_ts,
  input  logic        rst,
  input  logic [7:0]  ts_din,
  input  logic        ts_valid,
  input  logic        ts_sop,
  input  logic [1:0]  bank_rel_tgl,
  output logic        ram_wr,
  output logic [13:0] ram_waddr,
  output logic [63:0] ram_wdata,
  output logic [1:0]  bank_full,
  output logic        ts_ram_valid,
  output logic [15:0] drop_cnt
);

  localparam logic [8:0] LastPkt = 9'(PKTS_PER_BANK - 1);

  typedef enum logic [1:0] {StIdle, StFill, StDrop} state_e;

  state_e      state_q, state_d;
  logic        cur_q, cur_d;
  logic [8:0]  pkt_cnt_q, pkt_cnt_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [12:0] base_q, base_d;
  logic [55:0] pack_q, pack_d;
  logic        ram_wr_d;
  logic [13:0] ram_waddr_d;
  logic [63:0] ram_wdata_d;
  logic [15:0] drop_cnt_d;
  logic [1:0]  bank_set;
  logic [1:0]  rel_s1, rel_s2, rel_s3;
  logic [1:0]  rel_pulse;

  assign rel_pulse = rel_s2 ^ rel_s3;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    pkt_cnt_d   = pkt_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    base_d      = base_q;
    pack_d      = pack_q;
    ram_wr_d    = 1'b0;
    ram_waddr_d = ram_waddr;
    ram_wdata_d = ram_wdata;
    drop_cnt_d  = drop_cnt;
    bank_set    = 2'b00;

    if (ts_valid) begin
      if (ts_sop) begin
        // Any sop (even mid-packet) restarts evaluation; a bad sync byte just returns to idle.
        state_d    = StIdle;
        byte_cnt_d = 8'd0;
        if (ts_din == 8'h47) begin
          if (!bank_full[cur_q]) begin
            state_d    = StFill;
            pack_d     = {pack_q[47:0], ts_din};
            byte_cnt_d = 8'd1;
            base_d     = {4'b0, pkt_cnt_q} * 13'd24;
          end else begin
            state_d = StDrop;
            if (drop_cnt != 16'hFFFF) drop_cnt_d = drop_cnt + 16'd1;
          end
        end
      end else if (state_q == StFill) begin
        pack_d     = {pack_q[47:0], ts_din};
        byte_cnt_d = byte_cnt_q + 8'd1;
        if (byte_cnt_q[2:0] == 3'd7) begin
          ram_wr_d    = 1'b1;
          ram_waddr_d = {cur_q, base_q + {8'b0, byte_cnt_q[7:3]}};
          ram_wdata_d = {pack_q, ts_din};
        end
        if (byte_cnt_q == 8'd187) begin
          ram_wr_d    = 1'b1;
          ram_waddr_d = {cur_q, base_q + 13'd23};
          ram_wdata_d = {pack_q[23:0], ts_din, {4{PAD_BYTE}}};
          state_d     = StIdle;
          byte_cnt_d  = 8'd0;
          if (pkt_cnt_q == LastPkt) begin
            pkt_cnt_d       = 9'd0;
            bank_set[cur_q] = 1'b1;
            cur_d           = ~cur_q;
          end else begin
            pkt_cnt_d = pkt_cnt_q + 9'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_ts) begin
    if (rst) begin
      state_q      <= StIdle;
      cur_q        <= 1'b0;
      pkt_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      base_q       <= '0;
      pack_q       <= '0;
      ram_wr       <= 1'b0;
      ram_waddr    <= '0;
      ram_wdata    <= '0;
      bank_full    <= 2'b00;
      ts_ram_valid <= 1'b0;
      drop_cnt     <= '0;
      // Preload with the live toggle level so reset never looks like a release edge.
      rel_s1       <= bank_rel_tgl;
      rel_s2       <= bank_rel_tgl;
      rel_s3       <= bank_rel_tgl;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      pkt_cnt_q    <= pkt_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      base_q       <= base_d;
      pack_q       <= pack_d;
      ram_wr       <= ram_wr_d;
      ram_waddr    <= ram_waddr_d;
      ram_wdata    <= ram_wdata_d;
      bank_full    <= (bank_full & ~rel_pulse) | bank_set;
      ts_ram_valid <= |bank_full;
      drop_cnt     <= drop_cnt_d;
      rel_s1       <= bank_rel_tgl;
      rel_s2       <= rel_s1;
      rel_s3       <= rel_s2;
    end
  end

endmodule

// File: tb/tb_ts_ram_pingpong_wr.sv
// Directed bench for ts_ram_pingpong_wr: three instances (256, 2 and 1 packets per bank)
// share the stimulus; a selector picks which one is monitored and checked.
module tb_ts_ram_pingpong_wr;

  logic        clk_ts = 1'b0;
  logic        rst;
  logic [7:0]  ts_din;
  logic        ts_valid, ts_sop;
  logic [1:0]  bank_rel_tgl;

  logic        wr_a, wr_b, wr_c;
  logic [13:0] wa_a, wa_b, wa_c;
  logic [63:0] wd_a, wd_b, wd_c;
  logic [1:0]  bf_a, bf_b, bf_c;
  logic        tv_a, tv_b, tv_c;
  logic [15:0] dc_a, dc_b, dc_c;

  logic        m_wr;
  logic [13:0] m_waddr;
  logic [63:0] m_wdata;
  logic [1:0]  m_bf;
  logic        m_tv;
  logic [15:0] m_drop;

  int sel = 0;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int tv_rise = -1;
  logic tv_prev = 1'b0;

  logic [13:0] wr_addr[$];
  logic [63:0] wr_data[$];
  int          wr_cyc[$];
  logic [1:0]  wr_bf[$];
  int          exp_cyc[$];
  logic [63:0] mem [logic [13:0]];

  always #5 clk_ts = ~clk_ts;

  ts_ram_pingpong_wr u_dut_a (
    .clk_ts(clk_ts), .rst(rst), .ts_din(ts_din), .ts_valid(ts_valid), .ts_sop(ts_sop),
    .bank_rel_tgl(bank_rel_tgl), .ram_wr(wr_a), .ram_waddr(wa_a), .ram_wdata(wd_a),
    .bank_full(bf_a), .ts_ram_valid(tv_a), .drop_cnt(dc_a)
  );

  ts_ram_pingpong_wr #(.PKTS_PER_BANK(1)) u_dut_b (
    .clk_ts(clk_ts), .rst(rst), .ts_din(ts_din), .ts_valid(ts_valid), .ts_sop(ts_sop),
    .bank_rel_tgl(bank_rel_tgl), .ram_wr(wr_b), .ram_waddr(wa_b), .ram_wdata(wd_b),
    .bank_full(bf_b), .ts_ram_valid(tv_b), .drop_cnt(dc_b)
  );

  ts_ram_pingpong_wr #(.PKTS_PER_BANK(2)) u_dut_c (
    .clk_ts(clk_ts), .rst(rst), .ts_din(ts_din), .ts_valid(ts_valid), .ts_sop(ts_sop),
    .bank_rel_tgl(bank_rel_tgl), .ram_wr(wr_c), .ram_waddr(wa_c), .ram_wdata(wd_c),
    .bank_full(bf_c), .ts_ram_valid(tv_c), .drop_cnt(dc_c)
  );

  always_comb begin
    case (sel)
      1: begin m_wr = wr_b; m_waddr = wa_b; m_wdata = wd_b; m_bf = bf_b; m_tv = tv_b; m_drop = dc_b; end
      2: begin m_wr = wr_c; m_waddr = wa_c; m_wdata = wd_c; m_bf = bf_c; m_tv = tv_c; m_drop = dc_c; end
      default: begin
        m_wr = wr_a; m_waddr = wa_a; m_wdata = wd_a; m_bf = bf_a; m_tv = tv_a; m_drop = dc_a;
      end
    endcase
  end

  always @(posedge clk_ts) begin
    cyc = cyc + 1;
    #1;
    if (m_wr) begin
      wr_addr.push_back(m_waddr);
      wr_data.push_back(m_wdata);
      wr_cyc.push_back(cyc);
      wr_bf.push_back(m_bf);
      mem[m_waddr] = m_wdata;
    end
    if (m_tv && !tv_prev) tv_rise = cyc;
    tv_prev = m_tv;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pkt_byte(input int i, input int seed);
    if (i == 0) return 8'h47;
    return 8'((i + seed) & 255);
  endfunction

  function automatic logic [63:0] exp_word(input int w, input int seed);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      r = {r[55:0], ((w * 8 + j) < 188) ? pkt_byte(w * 8 + j, seed) : 8'hFF};
    end
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_ts);
      ts_valid = 1'b0;
      ts_sop   = 1'b0;
      ts_din   = 8'h00;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_ts);
    rst = 1'b1;
    ts_valid = 1'b0;
    ts_sop = 1'b0;
    ts_din = 8'h00;
    @(negedge clk_ts);
    @(negedge clk_ts);
    rst = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    wr_bf.delete();
    exp_cyc.delete();
    mem.delete();
    tv_rise = -1;
  endtask

  task automatic send_pkt(input int seed, input int nbytes, input logic [7:0] first,
                          input bit gap);
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk_ts);
      ts_din   = (i == 0) ? first : pkt_byte(i, seed);
      ts_valid = 1'b1;
      ts_sop   = (i == 0);
      if ((i % 8) == 7 || i == 187) exp_cyc.push_back(cyc + 1);
      if (gap) begin
        @(negedge clk_ts);
        ts_valid = 1'b0;
        ts_sop   = 1'b0;
      end
    end
  endtask

  task automatic check_pkt(input string tag, input int base, input int seed, input int k);
    if (wr_addr.size() < k + 24) begin
      check_val({tag, "_count"}, 64'(wr_addr.size()), 64'(k + 24));
      return;
    end
    for (int w = 0; w < 24; w++) begin
      check_val({tag, "_addr"}, 64'(wr_addr[k + w]), 64'(base + w));
      check_val({tag, "_data"}, wr_data[k + w], exp_word(w, seed));
    end
  endtask

  task automatic check_latency(input string tag);
    int nbad;
    nbad = (wr_cyc.size() != exp_cyc.size()) ? 1 : 0;
    for (int k = 0; k < wr_cyc.size() && k < exp_cyc.size(); k++)
      if (wr_cyc[k] != exp_cyc[k]) nbad++;
    check_val(tag, 64'(nbad), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    ts_din = 8'h00;
    ts_valid = 1'b0;
    ts_sop = 1'b0;
    bank_rel_tgl = 2'b00;

    // Reset values and one clean packet.
    sel = 0;
    do_reset();
    check_val("rst_wr", 64'(m_wr), 64'd0);
    check_val("rst_waddr", 64'(m_waddr), 64'd0);
    check_val("rst_wdata", m_wdata, 64'd0);
    check_val("rst_bank_full", 64'(m_bf), 64'd0);
    check_val("rst_ts_ram_valid", 64'(m_tv), 64'd0);
    check_val("rst_drop_cnt", 64'(m_drop), 64'd0);
    send_pkt(0, 188, 8'h47, 1'b0);
    idle(3);
    check_val("t1_count", 64'(wr_addr.size()), 64'd24);
    if (wr_data.size() == 24) begin
      check_val("t1_word0", wr_data[0], 64'h4701020304050607);
      check_val("t1_word23", wr_data[23], 64'hB8B9BABBFFFFFFFF);
    end
    check_pkt("t1", 0, 0, 0);
    check_latency("t1_latency");
    check_val("t1_hold_addr", 64'(m_waddr), 64'd23);
    check_val("t1_hold_data", m_wdata, 64'hB8B9BABBFFFFFFFF);

    // Same packet with a gap after every byte.
    do_reset();
    send_pkt(0, 188, 8'h47, 1'b1);
    idle(3);
    check_val("t2_count", 64'(wr_addr.size()), 64'd24);
    check_pkt("t2", 0, 0, 0);
    check_latency("t2_latency");

    // Two packets per bank: bank switch timing.
    sel = 2;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      send_pkt(0, 188, 8'h47, 1'b0);
      idle(2);
    end
    check_val("t3_count", 64'(wr_addr.size()), 64'd72);
    check_pkt("t3_p2", 24, 0, 24);
    check_pkt("t3_p3", 14'h2000, 0, 48);
    if (wr_bf.size() == 72) begin
      check_val("t3_bf_before", 64'(wr_bf[46]), 64'd0);
      check_val("t3_bf_at_wr23", 64'(wr_bf[47]), 64'd1);
      check_val("t3_tv_lag", 64'(tv_rise), 64'(wr_cyc[47] + 1));
    end
    check_val("t3_bf_end", 64'(m_bf), 64'd1);
    check_val("t3_tv_end", 64'(m_tv), 64'd1);

    // One packet per bank: drop when both full, then release bank 0.
    sel = 1;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      send_pkt(0, 188, 8'h47, 1'b0);
      idle(2);
    end
    check_val("t4_count", 64'(wr_addr.size()), 64'd48);
    check_pkt("t4_p2", 14'h2000, 0, 24);
    check_val("t4_bf", 64'(m_bf), 64'd3);
    check_val("t4_drop", 64'(m_drop), 64'd1);
    @(negedge clk_ts);
    bank_rel_tgl[0] = ~bank_rel_tgl[0];
    @(negedge clk_ts);
    check_val("t4_rel_c1", 64'(m_bf), 64'd3);
    @(negedge clk_ts);
    check_val("t4_rel_c2", 64'(m_bf), 64'd3);
    @(negedge clk_ts);
    check_val("t4_rel_c3", 64'(m_bf), 64'd2);
    send_pkt(5, 188, 8'h47, 1'b0);
    idle(2);
    check_val("t4_count2", 64'(wr_addr.size()), 64'd72);
    check_pkt("t4_p4", 0, 5, 48);
    check_val("t4_drop2", 64'(m_drop), 64'd1);

    // Sop at byte 100 aborts and restarts at the same base.
    sel = 0;
    do_reset();
    send_pkt(8'h55, 100, 8'h47, 1'b0);
    send_pkt(0, 188, 8'h47, 1'b0);
    idle(2);
    check_val("t5_count", 64'(wr_addr.size()), 64'd36);
    for (int w = 0; w < 24; w++)
      check_val("t5_mem", mem.exists(14'(w)) ? mem[14'(w)] : 64'hX, exp_word(w, 0));
    send_pkt(3, 188, 8'h47, 1'b0);
    idle(2);
    check_pkt("t5_next", 24, 3, 36);

    // Bad sync byte is ignored, not dropped.
    do_reset();
    send_pkt(8'h11, 51, 8'h00, 1'b0);
    send_pkt(0, 188, 8'h47, 1'b0);
    idle(2);
    check_val("t6_count", 64'(wr_addr.size()), 64'd24);
    check_pkt("t6", 0, 0, 0);
    check_val("t6_drop", 64'(m_drop), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
